seg_capture: RTL and testbench

- Read-back decoder for the multiplexed, active-low 7-segment display bus driven by the team's counter/display logic.
- Samples the segment and anode lines and filters out glitches and mux transitions.
- Decodes each stable glyph back to a 4-bit digit value and keeps a per-digit register file with valid, timeout and error flags.
- Used as an on-chip self-check and as a source for the bench scoreboard.

---
 rtl/seg_capture.sv | 150 +++++++++++++++
 tb/tb_seg_capture.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Read-back decoder for the multiplexed active-low 7-segment bus: filters, decodes and tracks each digit.
// Optional hex glyphs (A, C, d, E, F) are decoded when SEG_CAPTURE_HEX_DECODE_EN is defined.
module seg_capture #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  input  logic        clear_err,
  output logic [15:0] digit,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic [3:0]  seg_err,
  output logic        bus_err
);

  localparam int CW = $clog2(STABLE_CYC + 2);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] RUN_ACC = CW'(STABLE_CYC);
  localparam logic [CW-1:0] RUN_SAT = CW'(STABLE_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [7:0]    seg_s, seg_p;
  logic [3:0]    an_s, an_p;
  logic [CW-1:0] run_cnt;
  logic [TW-1:0] to_cnt [4];
  logic          accept;
  logic [3:0]    glyph_val;
  logic          glyph_ok;
  logic          sel_ok;
  logic          multi;
  logic [1:0]    sel_idx;
  logic [3:0]    cur_val;
  logic          new_dp;

  // The counter saturates one past the accept value so a long run fires exactly once.
  assign accept  = (run_cnt == RUN_ACC);
  assign cur_val = digit[{sel_idx, 2'b00} +: 4];
  assign new_dp  = ~seg_p[0];

  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'hF;
    case (seg_p[7:1])
      7'h01: glyph_val = 4'h0;
      7'h4F: glyph_val = 4'h1;
      7'h12: glyph_val = 4'h2;
      7'h06: glyph_val = 4'h3;
      7'h4C: glyph_val = 4'h4;
      7'h24: glyph_val = 4'h5;
      7'h60: glyph_val = 4'h6;
      7'h0F: glyph_val = 4'h7;
      7'h00: glyph_val = 4'h8;
      7'h0C: glyph_val = 4'h9;
      7'h7F: glyph_val = 4'hF;
`ifdef SEG_CAPTURE_HEX_DECODE_EN
      7'h08: glyph_val = 4'hA;
      7'h31: glyph_val = 4'hC;
      7'h42: glyph_val = 4'hD;
      7'h30: glyph_val = 4'hE;
      7'h38: glyph_val = 4'hF;
`endif
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    sel_ok  = 1'b0;
    multi   = 1'b0;
    sel_idx = 2'd0;
    case (an_p)
      4'b1110: begin sel_ok = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_ok = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_ok = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_ok = 1'b1; sel_idx = 2'd3; end
      4'b1111: ;
      default: multi = 1'b1;
    endcase
  end

  // Later assignments in this block override earlier ones, so an accept beats a timeout
  // and a new error beats clear_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s   <= 8'hFF;
      seg_p   <= 8'hFF;
      an_s    <= 4'hF;
      an_p    <= 4'hF;
      run_cnt <= '0;
      digit   <= 16'hFFFF;
      dp      <= 4'h0;
      valid   <= 4'h0;
      upd     <= 1'b0;
      upd_idx <= 2'd0;
      seg_err <= 4'h0;
      bus_err <= 1'b0;
      for (int i = 0; i < 4; i++) to_cnt[i] <= '0;
    end else begin
      seg_s <= seg;
      an_s  <= an;
      seg_p <= seg_s;
      an_p  <= an_s;
      if ({seg_s, an_s} != {seg_p, an_p})
        run_cnt <= CW'(1);
      else if (run_cnt != RUN_SAT)
        run_cnt <= run_cnt + CW'(1);

      upd <= 1'b0;
      if (clear_err) begin
        seg_err <= 4'h0;
        bus_err <= 1'b0;
      end

      for (int i = 0; i < 4; i++) begin
        if (valid[i]) begin
          if (to_cnt[i] == TO_LAST) begin
            valid[i]  <= 1'b0;
            to_cnt[i] <= '0;
          end else begin
            to_cnt[i] <= to_cnt[i] + TW'(1);
          end
        end
      end

      if (accept) begin
        if (multi) begin
          bus_err <= 1'b1;
        end else if (sel_ok) begin
          if (glyph_ok) begin
            digit[{sel_idx, 2'b00} +: 4] <= glyph_val;
            dp[sel_idx]     <= new_dp;
            valid[sel_idx]  <= 1'b1;
            to_cnt[sel_idx] <= '0;
            if (!valid[sel_idx] || cur_val != glyph_val || dp[sel_idx] != new_dp) begin
              upd     <= 1'b1;
              upd_idx <= sel_idx;
            end
          end else begin
            seg_err[sel_idx] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: one instance with a short timeout, one with the default timeout.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seg = 8'hFF;
  logic [3:0]  an = 4'hF;
  logic        clear_err = 1'b0;

  logic [15:0] digit_s, digit_f;
  logic [3:0]  dp_s, dp_f, valid_s, valid_f, seg_err_s, seg_err_f;
  logic        upd_s, upd_f, bus_err_s, bus_err_f;
  logic [1:0]  upd_idx_s, upd_idx_f;

  int checks = 0;
  int errors = 0;
  int upd_cnt;

  always #5 clk = ~clk;

  seg_capture #(.STABLE_CYC(4)) u_slow (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .clear_err(clear_err),
    .digit(digit_s), .dp(dp_s), .valid(valid_s), .upd(upd_s), .upd_idx(upd_idx_s),
    .seg_err(seg_err_s), .bus_err(bus_err_s)
  );

  seg_capture #(.STABLE_CYC(4), .TIMEOUT_CYC(16)) u_fast (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .clear_err(clear_err),
    .digit(digit_f), .dp(dp_f), .valid(valid_f), .upd(upd_f), .upd_idx(upd_idx_f),
    .seg_err(seg_err_f), .bus_err(bus_err_f)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tickCount(input int n);
    repeat (n) begin
      tick(1);
      if (upd_s) upd_cnt++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [3:0] a);
    seg = s;
    an  = a;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    checkOutput("rst_digit", digit_s, 16'hFFFF);
    checkOutput("rst_valid", {12'h0, valid_s}, 16'h0);
    checkOutput("rst_dp", {12'h0, dp_s}, 16'h0);
    checkOutput("rst_upd", {15'h0, upd_s}, 16'h0);
    checkOutput("rst_errs", {11'h0, bus_err_s, seg_err_s}, 16'h0);

    // digit 0 shows "0": accept lands on the 6th edge after the inputs change
    applyStimulus(8'b00000011, 4'b1110);
    tick(5);
    checkOutput("t1_valid_early", {12'h0, valid_s}, 16'h0);
    tick(1);
    checkOutput("t1_digit", digit_s, 16'hFFF0);
    checkOutput("t1_valid", {12'h0, valid_s}, 16'h0001);
    checkOutput("t1_dp", {12'h0, dp_s}, 16'h0);
    checkOutput("t1_upd", {15'h0, upd_s}, 16'h1);
    checkOutput("t1_upd_idx", {14'h0, upd_idx_s}, 16'h0);
    upd_cnt = 0;
    tickCount(8);
    checkOutput("t1_upd_once", 16'(upd_cnt), 16'd0);

    // digit 1 toggling every 2 cycles never settles
    upd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 8'b10011111 : 8'b00100101, 4'b1101);
      tickCount(2);
    end
    checkOutput("t2_upd_none", 16'(upd_cnt), 16'd0);
    checkOutput("t2_digit1", {12'h0, digit_s[7:4]}, 16'h000F);
    checkOutput("t2_valid1", {15'h0, valid_s[1]}, 16'h0);

    // illegal glyph on digit 2
    applyStimulus(8'b11100111, 4'b1011);
    tick(10);
    checkOutput("t3_seg_err", {12'h0, seg_err_s}, 16'h0004);
    checkOutput("t3_digit", digit_s, 16'hFFF0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    checkOutput("t3_cleared", {12'h0, seg_err_s}, 16'h0);

    // two anodes active at once
    applyStimulus(8'b00000001, 4'b0011);
    tick(10);
    checkOutput("t4_bus_err", {15'h0, bus_err_s}, 16'h1);
    checkOutput("t4_digit", digit_s, 16'hFFF0);
    checkOutput("t4_valid", {12'h0, valid_s}, 16'h0001);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    checkOutput("t4_cleared", {15'h0, bus_err_s}, 16'h0);

    // timeout on the short-timeout instance: valid[2] drops 16 edges after the accept edge
    applyStimulus(8'b00000001, 4'b1011);
    tick(6);
    checkOutput("t5_valid_set", {15'h0, valid_f[2]}, 16'h1);
    checkOutput("t5_digit2", {12'h0, digit_f[11:8]}, 16'h0008);
    applyStimulus(8'hFF, 4'hF);
    tick(15);
    checkOutput("t5_valid_hold", {15'h0, valid_f[2]}, 16'h1);
    tick(1);
    checkOutput("t5_valid_drop", {15'h0, valid_f[2]}, 16'h0);
    checkOutput("t5_digit2_keep", {12'h0, digit_f[11:8]}, 16'h0008);

    // reset part-way through a run restarts the stability count
    applyStimulus(8'b10011111, 4'b1101);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    checkOutput("rm_valid_early", {12'h0, valid_s}, 16'h0);
    tick(1);
    checkOutput("rm_valid", {12'h0, valid_s}, 16'h0002);
    checkOutput("rm_digit", digit_s, 16'hFF1F);

    // display mux sweep, two passes
    applyStimulus(8'hFF, 4'hF);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      upd_cnt = 0;
      applyStimulus(8'b10011111, 4'b1110); tickCount(8);
      applyStimulus(8'b00100101, 4'b1101); tickCount(8);
      applyStimulus(8'b00001101, 4'b1011); tickCount(8);
      applyStimulus(8'b10011001, 4'b0111); tickCount(8);
      checkOutput(pass == 0 ? "t6_upd_pass1" : "t6_upd_pass2", 16'(upd_cnt), pass == 0 ? 16'd4 : 16'd0);
    end
    checkOutput("t6_digit", digit_s, 16'h4321);
    checkOutput("t6_valid", {12'h0, valid_s}, 16'h000F);
    checkOutput("t6_dp", {12'h0, dp_s}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
